// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared opcode encodings for the multiply/divide unit.
// The instruction decoder and muldiv both import this package, so the
// encodings exist in exactly one place.
package muldiv_pkg;

  localparam logic [2:0] MD_MULT_OP  = 3'b000;
  localparam logic [2:0] MD_MULTU_OP = 3'b001;
  localparam logic [2:0] MD_DIV_OP   = 3'b010;
  localparam logic [2:0] MD_DIVU_OP  = 3'b011;
  localparam logic [2:0] MD_MTHI_OP  = 3'b100;
  localparam logic [2:0] MD_MTLO_OP  = 3'b101;

  // MULT/MULTU/DIV/DIVU: the iterative operations
  function automatic logic md_is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return ~op[2] & op[1];
  endfunction

  // MULT and DIV are the signed forms
  function automatic logic md_is_signed(input logic [2:0] op);
    return ~op[2] & ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_adder.sv
// adder: plain WIDTH-bit adder with carry in/out.
// Ports: op1, op2 (addends), cin (carry in), sum, carry (carry out).
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, op1} + {1'b0, op2} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/muldiv.sv
// muldiv: iterative multiply/divide unit owning the HI/LO registers.
// MULT/MULTU/DIV/DIVU take 33 cycles (32 iterations + 1 fix-up);
// MTHI/MTLO write HI/LO in a single cycle without raising busy.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   start_md_i, op_md_i          request and opcode (sampled in IDLE)
//   opr_a_md_i, opr_b_md_i       rs / rt operands
//   flush_md_i                   abort in-flight operation
//   busy_md_o, done_md_o         status; done pulses with the new HI/LO
//   hi_md_o, lo_md_o             HI/LO registers
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; MTHI/MTLO handled here
// CALC  | one multiply/divide iteration per cycle, count 0..31
// FIX   | sign correction / divide-by-zero override, write HI/LO on exit
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_md_i,
  input  logic [2:0]       op_md_i,
  input  logic [WIDTH-1:0] opr_a_md_i,
  input  logic [WIDTH-1:0] opr_b_md_i,
  input  logic             flush_md_i,
  output logic             busy_md_o,
  output logic             done_md_o,
  output logic [WIDTH-1:0] hi_md_o,
  output logic [WIDTH-1:0] lo_md_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t r_state, w_state_nxt;

  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_acc;       // product high half / partial remainder
  logic [WIDTH-1:0] r_q;         // multiplier (shifting out) / quotient
  logic [WIDTH-1:0] r_b;         // multiplicand / divisor magnitude
  logic [WIDTH-1:0] r_raw_a;     // raw dividend for the divide-by-zero result
  logic             r_is_div, r_div_zero, r_neg_res, r_neg_rem;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_busy, r_done;

  logic             w_start, w_load, w_iter, w_commit, w_mthi, w_mtlo;
  logic             w_signed, w_div;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH-1:0] w_add_op1, w_add_op2, w_sum;
  logic             w_add_cin, w_carry, w_ge;
  logic [WIDTH-1:0] w_shift_rem;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0] w_hi_fix, w_lo_fix;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start_md_i && !flush_md_i && md_is_arith(op_md_i)) w_state_nxt = S_CALC;
      S_CALC: if (flush_md_i) w_state_nxt = S_IDLE;
              else if (r_count == CW'(WIDTH-1)) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- control outputs ----------------
  always_comb begin
    w_start  = (r_state == S_IDLE) && start_md_i && !flush_md_i;
    w_load   = w_start && md_is_arith(op_md_i);
    w_mthi   = w_start && (op_md_i == MD_MTHI_OP);
    w_mtlo   = w_start && (op_md_i == MD_MTLO_OP);
    w_iter   = (r_state == S_CALC) && !flush_md_i;
    w_commit = (r_state == S_FIX) && !flush_md_i;
  end

  // ---------------- operand magnitudes ----------------
  assign w_signed = md_is_signed(op_md_i);
  assign w_div    = md_is_div(op_md_i);
  assign w_a_mag  = (w_signed && opr_a_md_i[WIDTH-1]) ? -opr_a_md_i : opr_a_md_i;
  assign w_b_mag  = (w_signed && opr_b_md_i[WIDTH-1]) ? -opr_b_md_i : opr_b_md_i;

  // ---------------- shared adder ----------------
  // Divide: trial subtract of the divisor from the shifted remainder
  // (op2 inverted, cin=1). Multiply: accumulate the multiplicand.
  assign w_shift_rem = {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
  assign w_add_op1   = r_is_div ? w_shift_rem : r_acc;
  assign w_add_op2   = r_is_div ? ~r_b : r_b;
  assign w_add_cin   = r_is_div;

  adder #(.WIDTH(WIDTH)) u_adder (
    .op1   (w_add_op1),
    .op2   (w_add_op2),
    .cin   (w_add_cin),
    .sum   (w_sum),
    .carry (w_carry)
  );

  // The shifted remainder is really WIDTH+1 bits; its dropped top bit set
  // means it certainly exceeds the divisor.
  assign w_ge = r_acc[WIDTH-1] | w_carry;

  // ---------------- fix-up ----------------
  assign w_prod = {r_acc, r_q};

  always_comb begin
    w_prod_fix = r_neg_res ? -w_prod : w_prod;
    w_hi_fix   = w_prod_fix[2*WIDTH-1:WIDTH];
    w_lo_fix   = w_prod_fix[WIDTH-1:0];
    if (r_is_div) begin
      if (r_div_zero) begin
        w_hi_fix = r_raw_a;
        w_lo_fix = '1;
      end else begin
        w_hi_fix = r_neg_rem ? -r_acc : r_acc;
        w_lo_fix = r_neg_res ? -r_q : r_q;
      end
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_acc      <= '0;
      r_q        <= '0;
      r_b        <= '0;
      r_raw_a    <= '0;
      r_is_div   <= 1'b0;
      r_div_zero <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= w_commit;
      if (w_load) begin
        r_count    <= '0;
        r_acc      <= '0;
        r_q        <= w_div ? w_a_mag : w_b_mag;
        r_b        <= w_div ? w_b_mag : w_a_mag;
        r_raw_a    <= opr_a_md_i;
        r_is_div   <= w_div;
        r_div_zero <= w_div && (opr_b_md_i == '0);
        r_neg_res  <= w_signed && (opr_a_md_i[WIDTH-1] ^ opr_b_md_i[WIDTH-1]);
        r_neg_rem  <= w_signed && opr_a_md_i[WIDTH-1];
      end
      if (w_iter) begin
        r_count <= r_count + 1'b1;
        if (r_is_div) begin
          r_acc <= w_ge ? w_sum : w_shift_rem;
          r_q   <= {r_q[WIDTH-2:0], w_ge};
        end else if (r_q[0]) begin
          {r_acc, r_q} <= {w_carry, w_sum, r_q[WIDTH-1:1]};
        end else begin
          {r_acc, r_q} <= {1'b0, r_acc, r_q[WIDTH-1:1]};
        end
      end
      if (w_commit) begin
        r_hi <= w_hi_fix;
        r_lo <= w_lo_fix;
      end
      if (w_mthi) r_hi <= opr_a_md_i;
      if (w_mtlo) r_lo <= opr_a_md_i;
    end
  end

  assign busy_md_o = r_busy;
  assign done_md_o = r_done;
  assign hi_md_o   = r_hi;
  assign lo_md_o   = r_lo;

endmodule

// File: tb/tb_muldiv.sv
module tb_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_total = 0;
  int n_bad   = 0;

  logic [63:0] exp_q[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  muldiv #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_md_i (start),
    .op_md_i    (op_i),
    .opr_a_md_i (a_i),
    .opr_b_md_i (b_i),
    .flush_md_i (flush),
    .busy_md_o  (busy),
    .done_md_o  (done),
    .hi_md_o    (hi),
    .lo_md_o    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: returns {HI, LO}
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (op)
      MD_MULT_OP:  res = 64'(sa * sb);
      MD_MULTU_OP: res = {32'h0, a} * {32'h0, b};
      MD_DIV_OP: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      MD_DIVU_OP: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = {model_hi, model_lo};
    endcase
    return res;
  endfunction

  // Entered and left at posedge+#1.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int n, nbusy;
    logic [63:0] e;
    exp_q.push_back(model(op, a, b));
    start = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    start = 1'b0; a_i = $urandom; b_i = $urandom; op_i = 3'($urandom);
    n = 0; nbusy = 0;
    while (!done && n < 40) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".lat"}, 64'(n), 64'd33);
    chk({tag, ".busy_cyc"}, 64'(nbusy), 64'd33);
    chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    e = exp_q.pop_front();
    chk({tag, ".hi"}, 64'(hi), 64'(e[63:32]));
    chk({tag, ".lo"}, 64'(lo), 64'(e[31:0]));
    model_hi = e[63:32];
    model_lo = e[31:0];
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    reset_n = 1'b0; start = 1'b0; flush = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.lo", 64'(lo), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(MD_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    chk("multu_max.hi_const", 64'(hi), 64'hFFFF_FFFE);
    run_op(MD_MULT_OP,  32'hFFFF_FFFD, 32'd7,         "mult_neg");
    run_op(MD_MULT_OP,  32'h8000_0000, 32'h8000_0000, "mult_min");
    run_op(MD_DIV_OP,   32'hFFFF_FFF9, 32'd2,         "div_neg");
    run_op(MD_DIV_OP,   32'd7,         32'hFFFF_FFFE, "div_negb");
    run_op(MD_DIV_OP,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    chk("div_ovf.lo_const", 64'(lo), 64'h8000_0000);
    run_op(MD_DIVU_OP,  32'd7,         32'd0,         "divu_zero");
    run_op(MD_DIV_OP,   32'hFFFF_FFF7, 32'd0,         "div_zero");
    run_op(MD_DIVU_OP,  32'hFFFF_FFFF, 32'd1,         "divu_one");

    for (int i = 0; i < 6; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      run_op(rop, ra, rb, $sformatf("rand%0d", i));
    end

    // Ignored start while busy, then flush in CALC
    start = 1'b1; op_i = MD_DIVU_OP; a_i = 32'd1000; b_i = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op_i = MD_MULTU_OP; a_i = 32'd5; b_i = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("flush.busy_mid", 64'(busy), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush.busy_low", 64'(busy), 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    chk("flush.no_done", 64'(ndone), 64'd0);
    chk("flush.hi", 64'(hi), 64'(model_hi));
    chk("flush.lo", 64'(lo), 64'(model_lo));

    // MTHI with same-cycle flush is dropped
    start = 1'b1; op_i = MD_MTHI_OP; a_i = 32'h1234_5678; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("mthi_flush.hi", 64'(hi), 64'(model_hi));
    chk("mthi_flush.busy", 64'(busy), 64'd0);

    // MTHI
    start = 1'b1; op_i = MD_MTHI_OP; a_i = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    model_hi = 32'h1234_5678;
    chk("mthi.hi", 64'(hi), 64'(model_hi));
    chk("mthi.lo", 64'(lo), 64'(model_lo));
    chk("mthi.busy", 64'(busy), 64'd0);
    chk("mthi.done", 64'(done), 64'd0);
    @(posedge clk); #1;
    chk("mthi.done_later", 64'(done), 64'd0);

    // MTLO
    start = 1'b1; op_i = MD_MTLO_OP; a_i = 32'hCAFE_F00D;
    @(posedge clk); #1;
    start = 1'b0;
    model_lo = 32'hCAFE_F00D;
    chk("mtlo.lo", 64'(lo), 64'(model_lo));
    chk("mtlo.hi", 64'(hi), 64'(model_hi));
    chk("mtlo.busy", 64'(busy), 64'd0);

    // Reserved opcode is ignored
    start = 1'b1; op_i = 3'b110; a_i = 32'hDEAD_BEEF; b_i = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    chk("resv.busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("resv.done", 64'(done), 64'd0);
    chk("resv.hi", 64'(hi), 64'(model_hi));
    chk("resv.lo", 64'(lo), 64'(model_lo));

    // Flush on the FIX exit edge wins
    start = 1'b1; op_i = MD_DIVU_OP; a_i = 32'd100; b_i = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    chk("fixflush.busy_in_fix", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fixflush.done", 64'(done), 64'd0);
    chk("fixflush.busy", 64'(busy), 64'd0);
    chk("fixflush.hi", 64'(hi), 64'(model_hi));
    chk("fixflush.lo", 64'(lo), 64'(model_lo));
    @(posedge clk); #1;
    chk("fixflush.done_later", 64'(done), 64'd0);

    // Reset in the middle of a MULT
    start = 1'b1; op_i = MD_MULT_OP; a_i = 32'd5; b_i = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.done", 64'(done), 64'd0);
    chk("midrst.hi", 64'(hi), 64'd0);
    chk("midrst.lo", 64'(lo), 64'd0);
    model_hi = '0;
    model_lo = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst.busy_after", 64'(busy), 64'd0);
    run_op(MD_MULTU_OP, 32'd2, 32'd3, "post_rst");
    chk("post_rst.lo_const", 64'(lo), 64'd6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
